digit_glyph_arbiter: RTL and testbench

- Shares one registered digit-glyph ROM (digits 0-9, 24 rows x 32 columns, 10-bit colour index per pixel) among NUM_REQ pixel requesters, e.g. timer, P1 score, P2 score and bomb count.
- Arbitrates round-robin, sequences ROM reads, and tracks outstanding reads with a credit counter.
- Returns tagged pixel colours in order through a small response FIFO with backpressure.
- Sits between the HUD/draw logic and the glyph ROM.

---
 rtl/hud_pkg.sv | 26 ++
 rtl/digit_glyph_arbiter_if.sv | 36 +++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/digit_glyph_arbiter.sv | 141 ++++++++++++++
 tb/tb_digit_glyph_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/hud_pkg.sv
// rtl/hud_pkg.sv - shared HUD glyph constants, request/response types and range check
package hud_pkg;

  localparam int GLYPH_H  = 24;
  localparam int GLYPH_W  = 32;
  localparam int MAX_ID_W = 3;

  // Sprite key colour: the blitter skips pixels of this index.
  localparam logic [9:0] TRANSPARENT = 10'd391;

  typedef struct packed {
    logic [3:0] digit;
    logic [4:0] row;
    logic [4:0] col;
  } glyph_req_t;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [9:0]          color;
  } glyph_rsp_t;

  function automatic logic glyph_bad(input glyph_req_t r, input int h, input int w);
    return (r.digit > 4'd9) || (int'(r.row) >= h) || (int'(r.col) >= w);
  endfunction

endpackage

// File: rtl/digit_glyph_arbiter_if.sv
// rtl/digit_glyph_arbiter_if.sv - requester, glyph ROM and response signals of the arbiter
interface digit_glyph_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int COLOR_W = 10
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0][3:0] req_digit;
  logic [NUM_REQ-1:0][4:0] req_row;
  logic [NUM_REQ-1:0][4:0] req_col;
  logic [NUM_REQ-1:0]      req_ready;

  logic                    rom_en;
  logic [3:0]              rom_digit;
  logic [4:0]              rom_row;
  logic [4:0]              rom_col;
  logic [COLOR_W-1:0]      rom_data;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [COLOR_W-1:0]      rsp_color;

  modport slave (
    input  req_valid, req_digit, req_row, req_col, rom_data, rsp_ready,
    output req_ready, rom_en, rom_digit, rom_row, rom_col, rsp_valid, rsp_id, rsp_color
  );

  modport master (
    output req_valid, req_digit, req_row, req_col, rom_data, rsp_ready,
    input  req_ready, rom_en, rom_digit, rom_row, rom_col, rsp_valid, rsp_id, rsp_color
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant; pointer moves past the winner on each grant
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_any
);

  logic [ID_W-1:0] ptr;
  int              idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_any && req[idx]) begin
          grant[idx] = 1'b1;
          grant_id   = ID_W'(idx);
          grant_any  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/digit_glyph_arbiter.sv
// rtl/digit_glyph_arbiter.sv - shares one registered digit-glyph ROM among NUM_REQ pixel requesters
module digit_glyph_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GLYPH_H = hud_pkg::GLYPH_H,
  parameter int GLYPH_W = hud_pkg::GLYPH_W,
  parameter int COLOR_W = 10,
  parameter int CREDITS = 4
) (
  input logic                  Clk,
  input logic                  Reset_n,
  digit_glyph_arbiter_if.slave bus
);

  import hud_pkg::*;

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = (CREDITS > 1) ? $clog2(CREDITS) : 1;
  localparam int CNT_W = $clog2(CREDITS + 1);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               hs;
  logic               credit_ok;
  logic [CNT_W-1:0]   cnt;
  glyph_req_t         sel_req;
  logic               sel_bad;

  logic               s1_valid, s1_bad, s2_valid, s2_bad;
  logic [ID_W-1:0]    s1_id, s2_id;
  logic               rom_en_q;
  glyph_req_t         rom_q;
  logic [COLOR_W-1:0] s2_color;

  logic [ID_W-1:0]    fifo_id    [CREDITS];
  logic [COLOR_W-1:0] fifo_color [CREDITS];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               push, pop;

  // Grants use the registered credit count only, so a pop frees a slot one cycle later.
  assign credit_ok = Reset_n && (cnt < CNT_W'(CREDITS));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .enable    (credit_ok),
    .req       (bus.req_valid),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (hs)
  );

  assign bus.req_ready = grant;

  always_comb begin
    sel_req       = '0;
    sel_req.digit = bus.req_digit[grant_id];
    sel_req.row   = bus.req_row[grant_id];
    sel_req.col   = bus.req_col[grant_id];
  end

  assign sel_bad = glyph_bad(sel_req, GLYPH_H, GLYPH_W);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_bad   <= 1'b0;
      s1_id    <= '0;
      rom_en_q <= 1'b0;
      rom_q    <= '0;
      s2_valid <= 1'b0;
      s2_bad   <= 1'b0;
      s2_id    <= '0;
    end else begin
      s1_valid <= hs;
      rom_en_q <= hs && !sel_bad;
      if (hs) begin
        s1_id  <= grant_id;
        s1_bad <= sel_bad;
        rom_q  <= sel_req;
      end
      s2_valid <= s1_valid;
      s2_bad   <= s1_bad;
      s2_id    <= s1_id;
    end
  end

  assign bus.rom_en    = rom_en_q;
  assign bus.rom_digit = rom_q.digit;
  assign bus.rom_row   = rom_q.row;
  assign bus.rom_col   = rom_q.col;

  // Out-of-range slots never touch the ROM; they return the key colour instead.
  assign s2_color = s2_bad ? COLOR_W'(TRANSPARENT) : bus.rom_data;

  assign push          = s2_valid;
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_valid = (fifo_cnt != '0);
  assign bus.rsp_id    = fifo_id[rd_ptr];
  assign bus.rsp_color = fifo_color[rd_ptr];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < CREDITS; i++) begin
        fifo_id[i]    <= '0;
        fifo_color[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_id[wr_ptr]    <= s2_id;
        fifo_color[wr_ptr] <= s2_color;
        wr_ptr <= (wr_ptr == PTR_W'(CREDITS - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(CREDITS - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credits span the whole pipeline plus FIFO, which bounds FIFO occupancy at CREDITS.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else begin
      case ({hs, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_glyph_arbiter.sv
// tb/tb_digit_glyph_arbiter.sv - directed self-checking bench for digit_glyph_arbiter
module tb_digit_glyph_arbiter;

  localparam int NUM_REQ = 4;
  localparam int COLOR_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [9:0] tbl_color [4] = '{10'd86, 10'd151, 10'd216, 10'd281};

  always #5 clk = ~clk;

  digit_glyph_arbiter_if #(.NUM_REQ(NUM_REQ), .COLOR_W(COLOR_W)) bus ();

  digit_glyph_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GLYPH_H (24),
    .GLYPH_W (32),
    .COLOR_W (COLOR_W),
    .CREDITS (4)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  function automatic logic [9:0] rom_f(input logic [3:0] d, input logic [4:0] r, input logic [4:0] c);
    return 10'(int'(d) * 38 + int'(r) * 4 + int'(c) * 3);
  endfunction

  always @(posedge clk) bus.rom_data <= bus.rom_en ? rom_f(bus.rom_digit, bus.rom_row, bus.rom_col) : 10'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] d, input logic [4:0] r, input logic [4:0] c);
    bus.req_digit[i] = d;
    bus.req_row[i]   = r;
    bus.req_col[i]   = c;
  endtask

  task automatic do_reset;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic run_single(input int id, input logic [3:0] d, input logic [4:0] r, input logic [4:0] c,
                            input logic en, input logic [9:0] color);
    set_req(id, d, r, c);
    bus.req_valid = 4'(1 << id);
    bus.rsp_ready = 1'b1;
    #1;
    check_eq("single_grant", 32'(bus.req_ready), 32'(1 << id));
    tick;
    bus.req_valid = '0;
    #1;
    check_eq("single_rom_en", 32'(bus.rom_en), 32'(en));
    if (en) begin
      check_eq("single_rom_digit", 32'(bus.rom_digit), 32'(d));
      check_eq("single_rom_row", 32'(bus.rom_row), 32'(r));
      check_eq("single_rom_col", 32'(bus.rom_col), 32'(c));
    end
    check_eq("single_early1", 32'(bus.rsp_valid), 32'd0);
    tick;
    check_eq("single_early2", 32'(bus.rsp_valid), 32'd0);
    tick;
    check_eq("single_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("single_id", 32'(bus.rsp_id), 32'(id));
    check_eq("single_color", 32'(bus.rsp_color), 32'(color));
    tick;
    check_eq("single_drained", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_digit = '0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state, with every requester asking.
    tick;
    bus.req_valid = 4'b1111;
    #1;
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_rom_en", 32'(bus.rom_en), 32'd0);
    check_eq("rst_rom_digit", 32'(bus.rom_digit), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check_eq("rst_rsp_color", 32'(bus.rsp_color), 32'd0);
    do_reset;

    // Single request, then out-of-range and in-range boundary fields.
    run_single(1, 4'd9, 5'd4, 5'd24, 1'b1, 10'd430);
    do_reset;
    run_single(2, 4'd12, 5'd0, 5'd0, 1'b0, 10'd391);
    run_single(2, 4'd3, 5'd24, 5'd0, 1'b0, 10'd391);
    run_single(3, 4'd10, 5'd0, 5'd0, 1'b0, 10'd391);
    run_single(2, 4'd3, 5'd23, 5'd31, 1'b1, 10'd299);

    // Full round-robin with sustained one-per-cycle responses.
    do_reset;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'(i + 2), 5'(3 * i + 1), 5'(5 * i + 2));
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc == 8) bus.req_valid = '0;
      #1;
      check_eq("rr_grant", 32'(bus.req_ready), (cyc < 8) ? 32'(1 << (cyc % 4)) : 32'd0);
      check_eq("rr_rsp_valid", 32'(bus.rsp_valid), (cyc >= 3) ? 32'd1 : 32'd0);
      if (cyc >= 3) begin
        check_eq("rr_rsp_id", 32'(bus.rsp_id), 32'((cyc - 3) % 4));
        check_eq("rr_rsp_color", 32'(bus.rsp_color), 32'(tbl_color[(cyc - 3) % 4]));
      end
      tick;
    end
    check_eq("rr_drained", 32'(bus.rsp_valid), 32'd0);

    // Backpressure: four credits, then a pop that frees a grant only on the next cycle.
    do_reset;
    set_req(0, 4'd1, 5'd2, 5'd3);
    bus.req_valid = 4'b0001;
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus.rsp_ready = (cyc == 7);
      #1;
      check_eq("bp_grant", 32'(bus.req_ready), (cyc < 4 || cyc == 8) ? 32'd1 : 32'd0);
      check_eq("bp_rsp_valid", 32'(bus.rsp_valid), (cyc >= 3) ? 32'd1 : 32'd0);
      if (cyc >= 3) begin
        check_eq("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
        check_eq("bp_rsp_color", 32'(bus.rsp_color), 32'd55);
      end
      tick;
    end

    // Reset with three responses outstanding.
    do_reset;
    for (int i = 1; i < NUM_REQ; i++) set_req(i, 4'(i + 2), 5'(3 * i + 1), 5'(5 * i + 2));
    bus.req_valid = 4'b1110;
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      check_eq("mid_grant", 32'(bus.req_ready), 32'(2 << cyc));
      tick;
    end
    bus.req_valid = '0;
    tick;
    tick;
    check_eq("mid_full_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("mid_full_id", 32'(bus.rsp_id), 32'd1);
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    check_eq("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("mid_rst_rom_en", 32'(bus.rom_en), 32'd0);
    tick;
    rst_n = 1'b1;
    set_req(0, 4'd7, 5'd0, 5'd0);
    bus.req_valid = 4'b1001;
    #1;
    check_eq("post_grant0", 32'(bus.req_ready), 32'd1);
    tick;
    bus.req_valid = 4'b1000;
    #1;
    check_eq("post_grant3", 32'(bus.req_ready), 32'd8);
    check_eq("post_stale1", 32'(bus.rsp_valid), 32'd0);
    tick;
    bus.req_valid = '0;
    check_eq("post_stale2", 32'(bus.rsp_valid), 32'd0);
    tick;
    bus.rsp_ready = 1'b1;
    check_eq("post_rsp0_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("post_rsp0_id", 32'(bus.rsp_id), 32'd0);
    check_eq("post_rsp0_color", 32'(bus.rsp_color), 32'd266);
    tick;
    check_eq("post_rsp1_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("post_rsp1_id", 32'(bus.rsp_id), 32'd3);
    check_eq("post_rsp1_color", 32'(bus.rsp_color), 32'd281);
    tick;
    check_eq("post_drained", 32'(bus.rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
